// File: rtl/rob_trap_ctrl.sv
// rob_trap_ctrl -- ROB trap-path sequencer.
//
// Accepts an exception (or, when ROB_TRAP_INTERRUPT_EN is defined, an
// interrupt) at the commit stage. It stalls commit, reads the fetch-block
// start address from the FTQ, forms the EPC, sends a one-cycle trap pulse to
// the CSR unit, then sends a one-cycle squash pulse to the trap vector and
// waits for pipeline recovery.
//
// Sequence: IDLE -> READ -> TRAP -> SQUASH -> RECOVER -> IDLE
//
// Optional feature macro: ROB_TRAP_INTERRUPT_EN
//   defined   : interrupt acceptance and vectored-mode trap vector offset
//   undefined : exceptions only, o_trap_is_int is always 0, and the squash
//               target is the tvec base
//
// Ports:
//   clk, rst               clock; asynchronous active-low reset
//   i_except_*             exception request from the ROB commit logic
//   i_commit_vld           at least one instruction committed this cycle
//   i_inst_*               FTQ index, offset and RVC flag of the trapping inst
//   i_last_is_mispred      last committed inst is a mispredicted branch
//   i_mispred_npc          correct target of that branch
//   i_interrupt_*          pending enabled interrupt from the CSR unit
//   o_ftq_idx              FTQ read index
//   i_ftq_startAddress     FTQ read data (combinational)
//   i_csr_tvec             trap vector; mode field in [1:0]
//   i_squash_done          pipeline recovery complete
//   o_commit_stall, o_busy stall ROB commit / block the ROB mispredict squash
//   o_trap_*               trap pulse and payload to the CSR unit
//   o_squash_vld/_pc       squash pulse and redirect target
module rob_trap_ctrl #(
    parameter int XLEN      = 64,
    parameter int FTQ_IDX_W = 4,
    parameter int FTQ_OFS_W = 5,
    parameter int CAUSE_W   = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_except_vld,
    input  logic [CAUSE_W-1:0]   i_except_cause,
    input  logic [XLEN-1:0]      i_except_tval,
    input  logic                 i_commit_vld,
    input  logic [FTQ_IDX_W-1:0] i_inst_ftq_idx,
    input  logic [FTQ_OFS_W-1:0] i_inst_ftqOffset,
    input  logic                 i_inst_isRVC,
    input  logic                 i_last_is_mispred,
    input  logic [XLEN-1:0]      i_mispred_npc,
    input  logic                 i_interrupt_pending,
    input  logic [CAUSE_W-1:0]   i_interrupt_cause,
    output logic [FTQ_IDX_W-1:0] o_ftq_idx,
    input  logic [XLEN-1:0]      i_ftq_startAddress,
    input  logic [XLEN-1:0]      i_csr_tvec,
    input  logic                 i_squash_done,
    output logic                 o_commit_stall,
    output logic                 o_busy,
    output logic                 o_trap_vld,
    output logic                 o_trap_is_int,
    output logic [CAUSE_W-1:0]   o_trap_cause,
    output logic [XLEN-1:0]      o_trap_epc,
    output logic [XLEN-1:0]      o_trap_tval,
    output logic                 o_squash_vld,
    output logic [XLEN-1:0]      o_squash_pc
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        TRAP,
        SQUASH,
        RECOVER
    } state_t;

    state_t               state;
    logic [CAUSE_W-1:0]   cause_q;
    logic [XLEN-1:0]      tval_q;
    logic [FTQ_OFS_W-1:0] ofs_q;
    logic                 rvc_q;
    logic                 is_int_q;
    logic [XLEN-1:0]      squash_pc_q;
    logic [XLEN-1:0]      epc_next;
    logic [XLEN-1:0]      squash_pc_next;
    logic [XLEN-1:0]      tvec_base;

`ifdef ROB_TRAP_INTERRUPT_EN
    logic                 mispred_q;
    logic [XLEN-1:0]      npc_q;
`else
    // Interrupt-only inputs and the tvec mode bits have no function here.
    logic unused_inputs;
    assign unused_inputs = ^{i_commit_vld, i_last_is_mispred, i_mispred_npc,
                             i_interrupt_pending, i_interrupt_cause,
                             i_csr_tvec[1:0]};
`endif

    assign tvec_base = {i_csr_tvec[XLEN-1:2], 2'b00};

    // EPC from the FTQ read data that is valid during READ.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        epc_next = i_ftq_startAddress + XLEN'(ofs_q);
`ifdef ROB_TRAP_INTERRUPT_EN
        // An interrupt resumes after the last committed instruction.
        if (is_int_q) begin
            if (mispred_q) begin
                epc_next = npc_q;
            end else begin
                epc_next = epc_next + (rvc_q ? XLEN'(2) : XLEN'(4));
            end
        end
`endif
    end

    always_comb begin
        squash_pc_next = tvec_base;
`ifdef ROB_TRAP_INTERRUPT_EN
        if (is_int_q && (i_csr_tvec[1:0] == 2'b01)) begin
            squash_pc_next = tvec_base + (XLEN'(cause_q) << 2);
        end
`endif
    end

    // The squash target is taken from tvec in the SQUASH cycle itself, so the
    // CSR write triggered by the trap pulse is already visible. At all other
    // times the last target is held.
    assign o_squash_pc = (state == SQUASH) ? squash_pc_next : squash_pc_q;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            cause_q        <= '0;
            tval_q         <= '0;
            ofs_q          <= '0;
            rvc_q          <= 1'b0;
            is_int_q       <= 1'b0;
            squash_pc_q    <= '0;
`ifdef ROB_TRAP_INTERRUPT_EN
            mispred_q      <= 1'b0;
            npc_q          <= '0;
`endif
            o_ftq_idx      <= '0;
            o_commit_stall <= 1'b0;
            o_busy         <= 1'b0;
            o_trap_vld     <= 1'b0;
            o_trap_is_int  <= 1'b0;
            o_trap_cause   <= '0;
            o_trap_epc     <= '0;
            o_trap_tval    <= '0;
            o_squash_vld   <= 1'b0;
        end else begin
            o_trap_vld   <= 1'b0;
            o_squash_vld <= 1'b0;
            case (state)
                IDLE: begin
                    // Stall stays high for the first IDLE cycle after RECOVER.
                    o_commit_stall <= 1'b0;
                    o_busy         <= 1'b0;
                    if (i_except_vld) begin
                        cause_q        <= i_except_cause;
                        tval_q         <= i_except_tval;
                        is_int_q       <= 1'b0;
                        o_ftq_idx      <= i_inst_ftq_idx;
                        ofs_q          <= i_inst_ftqOffset;
                        rvc_q          <= i_inst_isRVC;
                        o_commit_stall <= 1'b1;
                        o_busy         <= 1'b1;
                        state          <= READ;
`ifdef ROB_TRAP_INTERRUPT_EN
                        mispred_q      <= 1'b0;
                    end else if (i_interrupt_pending && i_commit_vld) begin
                        cause_q        <= i_interrupt_cause;
                        tval_q         <= '0;
                        is_int_q       <= 1'b1;
                        o_ftq_idx      <= i_inst_ftq_idx;
                        ofs_q          <= i_inst_ftqOffset;
                        rvc_q          <= i_inst_isRVC;
                        mispred_q      <= i_last_is_mispred;
                        npc_q          <= i_mispred_npc;
                        o_commit_stall <= 1'b1;
                        o_busy         <= 1'b1;
                        state          <= READ;
`endif
                    end
                end
                READ: begin
                    o_trap_vld    <= 1'b1;
                    o_trap_is_int <= is_int_q;
                    o_trap_cause  <= cause_q;
                    o_trap_epc    <= epc_next;
                    o_trap_tval   <= tval_q;
                    state         <= TRAP;
                end
                TRAP: begin
                    o_squash_vld <= 1'b1;
                    state        <= SQUASH;
                end
                SQUASH: begin
                    squash_pc_q <= squash_pc_next;
                    state       <= RECOVER;
                end
                RECOVER: begin
                    if (i_squash_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
